// File: rtl/operand_entry.sv
// Keypad operand-entry controller: builds a 2-digit decimal dividend and divisor from key strobes
// and presents them as binary, with a ready flag and a live BCD echo of both operands.
module operand_entry #(
   parameter int unsigned BIN_W    = 7,
   parameter logic [3:0]  KEY_NEXT = 4'hA,
   parameter logic [3:0]  KEY_BACK = 4'hB,
   parameter logic [3:0]  KEY_CLR  = 4'hC
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       tecla,
   input  logic             tecla_valida,
   output logic [BIN_W-1:0] A_bin,
   output logic [BIN_W-1:0] B_bin,
   output logic             ready_operands,
   output logic             ready_pulse,
   output logic             err_div0,
   output logic [15:0]      entry_bcd,
   output logic [1:0]       fase
);

   typedef enum logic [1:0] {
      StEnterA = 2'd0,
      StEnterB = 2'd1,
      StReady  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [3:0]       a_tens_q, a_tens_d, a_units_q, a_units_d;
   logic [3:0]       b_tens_q, b_tens_d, b_units_q, b_units_d;
   logic [1:0]       a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
   logic             err_q, err_d, pulse_q, pulse_d;
   logic [BIN_W-1:0] a_bin_q, a_bin_d, b_bin_q, b_bin_d;

   logic is_digit, is_next, is_back, is_clr, accepted;

   assign is_digit = tecla <= 4'd9;
   assign is_next  = tecla == KEY_NEXT;
   assign is_back  = tecla == KEY_BACK;
   assign is_clr   = tecla == KEY_CLR;
   // Unassigned codes (0xD-0xF by default) are not keypresses at all.
   assign accepted = tecla_valida && (is_digit || is_next || is_back || is_clr);

   always_comb begin
      state_d   = state_q;
      a_tens_d  = a_tens_q;
      a_units_d = a_units_q;
      b_tens_d  = b_tens_q;
      b_units_d = b_units_q;
      a_cnt_d   = a_cnt_q;
      b_cnt_d   = b_cnt_q;
      err_d     = err_q;

      if (accepted) begin
         err_d = 1'b0;
         if (is_clr) begin
            state_d   = StEnterA;
            a_tens_d  = 4'd0;
            a_units_d = 4'd0;
            b_tens_d  = 4'd0;
            b_units_d = 4'd0;
            a_cnt_d   = 2'd0;
            b_cnt_d   = 2'd0;
         end else begin
            unique case (state_q)
               StEnterA: begin
                  if (is_digit) begin
                     if (a_cnt_q < 2'd2) begin
                        a_tens_d  = a_units_q;
                        a_units_d = tecla;
                        a_cnt_d   = a_cnt_q + 2'd1;
                     end
                  end else if (is_next) begin
                     if (a_cnt_q != 2'd0) state_d = StEnterB;
                  end else if (is_back) begin
                     if (a_cnt_q != 2'd0) begin
                        a_units_d = a_tens_q;
                        a_tens_d  = 4'd0;
                        a_cnt_d   = a_cnt_q - 2'd1;
                     end
                  end
               end
               StEnterB: begin
                  if (is_digit) begin
                     if (b_cnt_q < 2'd2) begin
                        b_tens_d  = b_units_q;
                        b_units_d = tecla;
                        b_cnt_d   = b_cnt_q + 2'd1;
                     end
                  end else if (is_next) begin
                     if (b_cnt_q != 2'd0) begin
                        if (b_tens_q == 4'd0 && b_units_q == 4'd0) err_d = 1'b1;
                        else                                       state_d = StReady;
                     end
                  end else if (is_back) begin
                     if (b_cnt_q != 2'd0) begin
                        b_units_d = b_tens_q;
                        b_tens_d  = 4'd0;
                        b_cnt_d   = b_cnt_q - 2'd1;
                     end else begin
                        state_d = StEnterA;
                     end
                  end
               end
               StReady: begin
                  // A new digit starts a fresh calculation with that digit as A.
                  if (is_digit) begin
                     state_d   = StEnterA;
                     a_tens_d  = 4'd0;
                     a_units_d = tecla;
                     a_cnt_d   = 2'd1;
                     b_tens_d  = 4'd0;
                     b_units_d = 4'd0;
                     b_cnt_d   = 2'd0;
                  end else if (is_back) begin
                     state_d = StEnterB;
                  end
               end
               default: state_d = StEnterA;
            endcase
         end
      end

      a_bin_d = BIN_W'(a_tens_d) * BIN_W'(10) + BIN_W'(a_units_d);
      b_bin_d = BIN_W'(b_tens_d) * BIN_W'(10) + BIN_W'(b_units_d);
      pulse_d = (state_d == StReady) && (state_q != StReady);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= StEnterA;
         a_tens_q  <= 4'd0;
         a_units_q <= 4'd0;
         b_tens_q  <= 4'd0;
         b_units_q <= 4'd0;
         a_cnt_q   <= 2'd0;
         b_cnt_q   <= 2'd0;
         err_q     <= 1'b0;
         pulse_q   <= 1'b0;
         a_bin_q   <= '0;
         b_bin_q   <= '0;
      end else begin
         state_q   <= state_d;
         a_tens_q  <= a_tens_d;
         a_units_q <= a_units_d;
         b_tens_q  <= b_tens_d;
         b_units_q <= b_units_d;
         a_cnt_q   <= a_cnt_d;
         b_cnt_q   <= b_cnt_d;
         err_q     <= err_d;
         pulse_q   <= pulse_d;
         a_bin_q   <= a_bin_d;
         b_bin_q   <= b_bin_d;
      end
   end

   assign A_bin          = a_bin_q;
   assign B_bin          = b_bin_q;
   assign ready_operands = state_q == StReady;
   assign ready_pulse    = pulse_q;
   assign err_div0       = err_q;
   assign entry_bcd      = {a_tens_q, a_units_q, b_tens_q, b_units_q};
   assign fase           = state_q;

endmodule

// File: tb/tb_operand_entry.sv
// Bench for operand_entry: directed scenarios plus random key streams against a value-level model
// that tracks each operand as an integer and digit count.
module tb_operand_entry;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  tecla = 4'd0;
   logic        tecla_valida = 1'b0;
   logic [6:0]  A_bin, B_bin;
   logic        ready_operands, ready_pulse, err_div0;
   logic [15:0] entry_bcd;
   logic [1:0]  fase;

   int checks = 0;
   int errors = 0;

   // Model state: operands as plain integers, phase 0/1/2.
   int ma, mb, mca, mcb, mph;
   bit merr, mpulse;

   operand_entry dut (
      .clk           (clk),
      .rst           (rst),
      .tecla         (tecla),
      .tecla_valida  (tecla_valida),
      .A_bin         (A_bin),
      .B_bin         (B_bin),
      .ready_operands(ready_operands),
      .ready_pulse   (ready_pulse),
      .err_div0      (err_div0),
      .entry_bcd     (entry_bcd),
      .fase          (fase)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      ma = 0; mb = 0; mca = 0; mcb = 0; mph = 0; merr = 0; mpulse = 0;
   endtask

   task automatic model_key(input int k);
      int prev;
      prev = mph;
      if (k <= 12) begin
         merr = 0;
         if (k == 12) begin
            model_reset();
         end else if (k < 10) begin
            if (mph == 0 && mca < 2) begin ma = (ma % 10) * 10 + k; mca++; end
            else if (mph == 1 && mcb < 2) begin mb = (mb % 10) * 10 + k; mcb++; end
            else if (mph == 2) begin ma = k; mca = 1; mb = 0; mcb = 0; mph = 0; end
         end else if (k == 10) begin
            if (mph == 0 && mca > 0) mph = 1;
            else if (mph == 1 && mcb > 0) begin
               if (mb != 0) mph = 2;
               else merr = 1;
            end
         end else begin
            if (mph == 0 && mca > 0) begin ma = ma / 10; mca--; end
            else if (mph == 1) begin
               if (mcb > 0) begin mb = mb / 10; mcb--; end
               else mph = 0;
            end else if (mph == 2) mph = 1;
         end
      end
      mpulse = (mph == 2) && (prev != 2);
   endtask

   // One strobe; outputs are then sampled at the following negedge.
   task automatic press(input logic [3:0] k);
      @(negedge clk);
      tecla = k;
      tecla_valida = 1'b1;
      @(negedge clk);
      tecla_valida = 1'b0;
      tecla = 4'($urandom);
      model_key(int'(k));
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b0;
      tecla_valida = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      apply_reset();
      checks++; if (fase !== 2'd0) begin errors++; $display("FAIL reset_fase: got %0d want 0", fase); end
      checks++; if (A_bin !== 7'd0) begin errors++; $display("FAIL reset_a: got %0d want 0", A_bin); end
      checks++; if (B_bin !== 7'd0) begin errors++; $display("FAIL reset_b: got %0d want 0", B_bin); end
      checks++; if (entry_bcd !== 16'h0000) begin errors++; $display("FAIL reset_bcd: got %h want 0000", entry_bcd); end
      checks++; if (ready_operands !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready_operands); end
      checks++; if ({ready_pulse, err_div0} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {ready_pulse, err_div0}); end
   endtask

   task automatic test_basic();
      apply_reset();
      press(4'h8); press(4'h4); press(4'hA); press(4'h1); press(4'h2);
      checks++; if (ready_operands !== 1'b0) begin errors++; $display("FAIL basic_not_ready: got %b want 0", ready_operands); end
      press(4'hA);
      checks++; if (A_bin !== 7'd84) begin errors++; $display("FAIL basic_a: got %0d want 84", A_bin); end
      checks++; if (B_bin !== 7'd12) begin errors++; $display("FAIL basic_b: got %0d want 12", B_bin); end
      checks++; if (entry_bcd !== 16'h8412) begin errors++; $display("FAIL basic_bcd: got %h want 8412", entry_bcd); end
      checks++; if (ready_pulse !== 1'b1) begin errors++; $display("FAIL basic_pulse: got %b want 1", ready_pulse); end
      checks++; if (ready_operands !== 1'b1) begin errors++; $display("FAIL basic_ready: got %b want 1", ready_operands); end
      checks++; if (fase !== 2'd2) begin errors++; $display("FAIL basic_fase: got %0d want 2", fase); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if (ready_pulse !== 1'b0) begin errors++; $display("FAIL basic_pulse_drop: got %b want 0", ready_pulse); end
         checks++; if (ready_operands !== 1'b1) begin errors++; $display("FAIL basic_ready_hold: got %b want 1", ready_operands); end
      end
   endtask

   task automatic test_third_digit();
      apply_reset();
      press(4'h1); press(4'h2); press(4'h3);
      checks++; if (A_bin !== 7'd12) begin errors++; $display("FAIL third_a: got %0d want 12", A_bin); end
      checks++; if (entry_bcd !== 16'h1200) begin errors++; $display("FAIL third_bcd: got %h want 1200", entry_bcd); end
      press(4'hB);
      checks++; if (A_bin !== 7'd1) begin errors++; $display("FAIL back_a: got %0d want 1", A_bin); end
      checks++; if (entry_bcd !== 16'h0100) begin errors++; $display("FAIL back_bcd: got %h want 0100", entry_bcd); end
   endtask

   task automatic test_div0();
      apply_reset();
      press(4'h5); press(4'hA); press(4'h0); press(4'hA);
      checks++; if (err_div0 !== 1'b1) begin errors++; $display("FAIL div0_err: got %b want 1", err_div0); end
      checks++; if (fase !== 2'd1) begin errors++; $display("FAIL div0_fase: got %0d want 1", fase); end
      checks++; if (ready_operands !== 1'b0) begin errors++; $display("FAIL div0_ready: got %b want 0", ready_operands); end
      @(negedge clk);
      checks++; if (err_div0 !== 1'b1) begin errors++; $display("FAIL div0_hold: got %b want 1", err_div0); end
      press(4'h3);
      checks++; if (err_div0 !== 1'b0) begin errors++; $display("FAIL div0_clear: got %b want 0", err_div0); end
      checks++; if (B_bin !== 7'd3) begin errors++; $display("FAIL div0_b: got %0d want 3", B_bin); end
      press(4'hA);
      checks++; if (ready_operands !== 1'b1) begin errors++; $display("FAIL div0_ready_after: got %b want 1", ready_operands); end
   endtask

   task automatic test_ready_digit();
      apply_reset();
      press(4'h9); press(4'h9); press(4'hA); press(4'h9); press(4'hA);
      checks++; if (A_bin !== 7'd99) begin errors++; $display("FAIL rd_a99: got %0d want 99", A_bin); end
      press(4'h7);
      checks++; if (ready_operands !== 1'b0) begin errors++; $display("FAIL rd_ready: got %b want 0", ready_operands); end
      checks++; if (fase !== 2'd0) begin errors++; $display("FAIL rd_fase: got %0d want 0", fase); end
      checks++; if (A_bin !== 7'd7) begin errors++; $display("FAIL rd_a: got %0d want 7", A_bin); end
      checks++; if (B_bin !== 7'd0) begin errors++; $display("FAIL rd_b: got %0d want 0", B_bin); end
   endtask

   task automatic test_reset_mid_entry();
      apply_reset();
      press(4'h4); press(4'hA); press(4'h2);
      apply_reset();
      checks++; if ({A_bin, B_bin} !== 14'd0) begin errors++; $display("FAIL mid_bins: got %h want 0", {A_bin, B_bin}); end
      checks++; if ({entry_bcd, fase} !== 18'd0) begin errors++; $display("FAIL mid_bcd_fase: got %h want 0", {entry_bcd, fase}); end
      checks++; if ({ready_operands, ready_pulse, err_div0} !== 3'd0) begin errors++; $display("FAIL mid_flags: got %b want 000", {ready_operands, ready_pulse, err_div0}); end
   endtask

   task automatic test_no_strobe();
      apply_reset();
      press(4'h3); press(4'hA); press(4'h5);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         tecla = 4'(i);
         checks++; if (entry_bcd !== 16'h0305 || fase !== 2'd1) begin
            errors++; $display("FAIL no_strobe: got bcd %h fase %0d want 0305 fase 1", entry_bcd, fase);
         end
      end
   endtask

   task automatic test_random();
      logic [3:0] k, et, eu, ft, fu;
      apply_reset();
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 59) == 0) begin
            apply_reset();
         end else begin
            if ($urandom_range(0, 1) == 0) k = 4'($urandom_range(0, 9));
            else                           k = 4'($urandom_range(10, 15));
            // Bias toward NEXT so READY is visited often.
            if ($urandom_range(0, 3) == 0) k = 4'hA;
            press(k);
         end
         et = 4'(ma / 10); eu = 4'(ma % 10); ft = 4'(mb / 10); fu = 4'(mb % 10);
         checks++; if (A_bin !== 7'(ma)) begin errors++; $display("FAIL rnd_a: got %0d want %0d", A_bin, ma); end
         checks++; if (B_bin !== 7'(mb)) begin errors++; $display("FAIL rnd_b: got %0d want %0d", B_bin, mb); end
         checks++; if (entry_bcd !== {et, eu, ft, fu}) begin errors++; $display("FAIL rnd_bcd: got %h want %h", entry_bcd, {et, eu, ft, fu}); end
         checks++; if (fase !== 2'(mph)) begin errors++; $display("FAIL rnd_fase: got %0d want %0d", fase, mph); end
         checks++; if (ready_operands !== (mph == 2)) begin errors++; $display("FAIL rnd_ready: got %b want %b", ready_operands, mph == 2); end
         checks++; if (ready_pulse !== mpulse) begin errors++; $display("FAIL rnd_pulse: got %b want %b", ready_pulse, mpulse); end
         checks++; if (err_div0 !== merr) begin errors++; $display("FAIL rnd_err: got %b want %b", err_div0, merr); end
      end
   endtask

   initial begin
      model_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      test_reset();
      test_basic();
      test_third_digit();
      test_div0();
      test_ready_digit();
      test_reset_mid_entry();
      test_no_strobe();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
